// File: rtl/edge_result_writer.sv
// Result sink: buffers qualified {x,y} edge results in a small FIFO and writes one frame of
// IMG_W*IMG_H results to memory at base_addr onward. Define EDGE_WRITER_MAG_EN to store |x|+|y|.
module edge_result_writer #(
  parameter int unsigned IMG_W      = 128,
  parameter int unsigned IMG_H      = 128,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_x_i,
  input  logic [7:0]        in_y_i,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);

  localparam int unsigned Total = IMG_W * IMG_H;
  localparam int unsigned CntW  = $clog2(Total + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW  = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [CntW-1:0] TotalC = CntW'(Total);
  localparam logic [OccW-1:0] DepthC = OccW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
  state_e state_q, state_d;

  logic [15:0]       fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OccW-1:0]   fcnt_q, fcnt_d, occ;
  logic [CntW-1:0]   acc_cnt_q, acc_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d, mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d, push_data;
  logic              mem_we_q, mem_we_d, overflow_q, overflow_d;
  logic              start_acc, complete, full, push, pop, drop;

`ifdef EDGE_WRITER_MAG_EN
  logic [8:0] mag_sum;
  assign mag_sum   = {1'b0, in_x_i} + {1'b0, in_y_i};
  assign push_data = {8'h00, mag_sum[8] ? 8'hFF : mag_sum[7:0]};
`else
  assign push_data = {in_x_i, in_y_i};
`endif

  // The output register counts as one FIFO slot, so DEPTH results are held under a full stall.
  always_comb begin
    start_acc = (state_q == StIdle) && start_i;
    complete  = mem_we_q && mem_ready_i;
    occ       = fcnt_q + OccW'(mem_we_q);
    full      = (occ == DepthC);
    pop       = (fcnt_q != '0) && (!mem_we_q || mem_ready_i);
    push      = (state_q == StRun) && in_valid_i && (!full || complete);
    drop      = (state_q == StRun) && in_valid_i && full && !complete;
  end

  always_comb begin
    wptr_d      = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d      = pop ? rptr_q + PtrW'(1) : rptr_q;
    fcnt_d      = fcnt_q + OccW'(push) - OccW'(pop);
    acc_cnt_d   = acc_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    next_addr_d = next_addr_q;
    overflow_d  = overflow_q;
    if (start_acc) begin
      acc_cnt_d   = '0;
      wr_cnt_d    = '0;
      next_addr_d = base_addr_i;
      overflow_d  = 1'b0;
    end else begin
      if (push)     acc_cnt_d   = acc_cnt_q + CntW'(1);
      if (complete) wr_cnt_d    = wr_cnt_q + CntW'(1);
      if (pop)      next_addr_d = next_addr_q + ADDR_W'(1);
      if (drop)     overflow_d  = 1'b1;
    end
    mem_we_d    = pop ? 1'b1 : (complete ? 1'b0 : mem_we_q);
    mem_addr_d  = pop ? next_addr_q : mem_addr_q;
    mem_wdata_d = pop ? fifo_q[rptr_q] : mem_wdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= push_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      fcnt_q      <= '0;
      acc_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      next_addr_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fcnt_q      <= fcnt_d;
      acc_cnt_q   <= acc_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      next_addr_q <= next_addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // DRAIN exits on the edge that completes the final write, so done follows it directly.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (acc_cnt_d == TotalC) state_d = StDrain;
      StDrain: if (wr_cnt_d == TotalC) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o      = (state_q == StRun) || (state_q == StDrain);
    done_o      = (state_q == StDone);
    overflow_o  = overflow_q;
    mem_we_o    = mem_we_q;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
  end

endmodule

// File: tb/tb_edge_result_writer.sv
// Directed bench for edge_result_writer with a 4x2 frame and a 4-entry FIFO.
module tb_edge_result_writer;

  localparam int unsigned W = 4, H = 2, AW = 16, FD = 4;
`ifdef EDGE_WRITER_MAG_EN
  localparam bit Mag = 1'b1;
`else
  localparam bit Mag = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, mem_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    in_x = '0, in_y = '0;
  logic          mem_we, busy, done, overflow;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;

  edge_result_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
    .in_valid_i(in_valid), .in_x_i(in_x), .in_y_i(in_y), .mem_ready_i(mem_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .busy_o(busy), .done_o(done), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] addr;
    logic [15:0] raw;
    logic [15:0] mag;
  } vec_t;
  vec_t tv1[8], tv2[8];

  int compared = 0, mismatched = 0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, last_wr_cyc = -1;
  logic [15:0] wa[$], wd[$], ea[$], ed[$];
  int wc[$];
  logic [15:0] exp_addr = '0;
  logic pw = 1'b0, pr = 1'b0;
  logic [15:0] pa = '0, pd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] model_data(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (Mag) return {8'h00, (s > 9'd255) ? 8'hFF : s[7:0]};
    return {x, y};
  endfunction

  always @(posedge clk) cyc++;

  // Log completed writes and check that a stalled write holds its address and data.
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (pw && !pr && rst_n) begin
      chk("stall_we", 32'(mem_we), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'(pa));
      chk("stall_data", 32'(mem_wdata), 32'(pd));
    end
    pw = mem_we; pr = mem_ready; pa = mem_addr; pd = mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b);
    wa.delete(); wd.delete(); wc.delete(); ea.delete(); ed.delete();
    exp_addr = b;
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] x, input logic [7:0] y, input bit acc);
    in_valid = 1'b1; in_x = x; in_y = y;
    if (acc) begin
      ea.push_back(exp_addr);
      ed.push_back(model_data(x, y));
      exp_addr = exp_addr + 16'd1;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n0, k;
    n0 = done_cnt;
    k = 0;
    while (done_cnt == n0 && k < 200) begin
      tick();
      k++;
    end
    repeat (3) tick();
    chk({tag, "_done_pulses"}, 32'(done_cnt - n0), 32'd1);
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_nwrites"}, 32'(wa.size()), 32'(ea.size()));
    for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(ea[i]));
      chk($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(ed[i]));
    end
  endtask

  task automatic compare_table(input string tag, input vec_t tv[8]);
    chk({tag, "_nwrites"}, 32'(wa.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wa.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(tv[i].addr));
        chk($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(Mag ? tv[i].mag : tv[i].raw));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int c0, n0;
    tv1[0] = '{8'h00, 8'h10, 16'h0100, 16'h0010, 16'h0010};
    tv1[1] = '{8'h01, 8'h11, 16'h0101, 16'h0111, 16'h0012};
    tv1[2] = '{8'h02, 8'h12, 16'h0102, 16'h0212, 16'h0014};
    tv1[3] = '{8'h03, 8'h13, 16'h0103, 16'h0313, 16'h0016};
    tv1[4] = '{8'h04, 8'h14, 16'h0104, 16'h0414, 16'h0018};
    tv1[5] = '{8'h05, 8'h15, 16'h0105, 16'h0515, 16'h001A};
    tv1[6] = '{8'h06, 8'h16, 16'h0106, 16'h0616, 16'h001C};
    tv1[7] = '{8'h07, 8'h17, 16'h0107, 16'h0717, 16'h001E};
    tv2[0] = '{8'hF0, 8'h20, 16'hFFFE, 16'hF020, 16'h00FF};
    tv2[1] = '{8'h12, 8'h34, 16'hFFFF, 16'h1234, 16'h0046};
    tv2[2] = '{8'hFF, 8'hFF, 16'h0000, 16'hFFFF, 16'h00FF};
    tv2[3] = '{8'h80, 8'h80, 16'h0001, 16'h8080, 16'h00FF};
    tv2[4] = '{8'h7F, 8'h80, 16'h0002, 16'h7F80, 16'h00FF};
    tv2[5] = '{8'h00, 8'h00, 16'h0003, 16'h0000, 16'h0000};
    tv2[6] = '{8'h01, 8'h02, 16'h0004, 16'h0102, 16'h0003};
    tv2[7] = '{8'h3C, 8'h5A, 16'h0005, 16'h3C5A, 16'h0096};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // in_valid while idle must not write
    for (int i = 0; i < 4; i++) feed(8'hAA, 8'hBB, 1'b0);
    repeat (4) tick();
    chk("idle_nwrites", 32'(wa.size()), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic frame from the table
    do_start(16'h0100);
    chk("f1_busy", 32'(busy), 32'd1);
    c0 = cyc;
    for (int i = 0; i < 8; i++) feed(tv1[i].x, tv1[i].y, 1'b1);
    wait_done("f1");
    compare_table("f1", tv1);
    if (wc.size() == 8) begin
      chk("f1_latency", 32'(wc[0]), 32'(c0 + 2));
      chk("f1_throughput", 32'(wc[7] - wc[0]), 32'd7);
    end else chk("f1_wc_size", 32'(wc.size()), 32'd8);
    chk("f1_done_cycle", 32'(done_cyc), 32'(last_wr_cyc + 1));
    chk("f1_busy_after", 32'(busy), 32'd0);
    chk("f1_ovf", 32'(overflow), 32'd0);

    // Backpressure: ready low for 5 cycles, results every other cycle
    do_start(16'h0200);
    for (int t = 0; t < 16; t++) begin
      mem_ready = !(t >= 4 && t <= 8);
      if (t % 2 == 0) feed(8'(8'h20 + t / 2), 8'(8'h30 + t / 2), 1'b1);
      else tick();
    end
    mem_ready = 1'b1;
    wait_done("bp");
    compare_writes("bp");
    chk("bp_ovf", 32'(overflow), 32'd0);

    // Overflow: ready held low, six results offered, four fit
    mem_ready = 1'b0;
    do_start(16'h0300);
    for (int i = 0; i < 6; i++) feed(8'(8'h40 + i), 8'(8'h50 + i), i < 4);
    chk("ov_flag", 32'(overflow), 32'd1);
    chk("ov_nwrites_stalled", 32'(wa.size()), 32'd0);
    n0 = done_cnt;
    mem_ready = 1'b1;
    repeat (8) tick();
    chk("ov_nwrites_mid", 32'(wa.size()), 32'd4);
    chk("ov_no_early_done", 32'(done_cnt - n0), 32'd0);
    chk("ov_busy_mid", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) feed(8'(8'h60 + i), 8'(8'h70 + i), 1'b1);
    wait_done("ov");
    compare_writes("ov");
    chk("ov_sticky", 32'(overflow), 32'd1);

    // start during RUN is ignored
    do_start(16'h0400);
    chk("sr_ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) feed(8'(8'h80 + i), 8'(8'h90 + i), 1'b1);
    base_addr = 16'h0900;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 3; i < 8; i++) feed(8'(8'h80 + i), 8'(8'h90 + i), 1'b1);
    wait_done("sr");
    compare_writes("sr");

    // Ten results offered, only eight taken
    do_start(16'h0500);
    for (int i = 0; i < 10; i++) feed(8'(8'hA0 + i), 8'(8'hB0 + i), i < 8);
    wait_done("x10");
    repeat (5) tick();
    compare_writes("x10");
    chk("x10_ovf", 32'(overflow), 32'd0);

    // Address wrap, plus magnitude saturation cases when enabled
    do_start(16'hFFFE);
    for (int i = 0; i < 8; i++) feed(tv2[i].x, tv2[i].y, 1'b1);
    wait_done("wrap");
    compare_table("wrap", tv2);

    // Reset after three writes abandons the frame
    do_start(16'h0600);
    for (int i = 0; i < 8; i++) begin
      feed(8'(8'hC0 + i), 8'(8'hD0 + i), 1'b1);
      if (wa.size() >= 3) break;
    end
    n0 = done_cnt;
    #3 rst_n = 1'b0;
    #1;
    chk("mr_we", 32'(mem_we), 32'd0);
    chk("mr_addr", 32'(mem_addr), 32'd0);
    chk("mr_data", 32'(mem_wdata), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mr_nwrites", 32'(wa.size()), 32'd3);
    chk("mr_no_done", 32'(done_cnt - n0), 32'd0);
    do_start(16'h0700);
    for (int i = 0; i < 8; i++) feed(8'(8'hE0 + i), 8'(8'hF0 + i), 1'b1);
    wait_done("mr2");
    compare_writes("mr2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/edge_result_writer.md
Name: edge_result_writer

Overview:
- Sink at the output end of the edge-detection pipeline: takes qualified out_x/out_y result pairs and writes them into a result frame buffer.
- Writes go out over a ready-qualified write port with linear address generation, starting at a base address.
- A small FIFO decouples the free-running result stream from memory backpressure.
- Frame-level control: start, done and sticky overflow report.

Parameters:
- IMG_W, 128, results per line
- IMG_H, 128, lines per frame; total results T = IMG_W*IMG_H
- ADDR_W, 16, memory address width; T must be no greater than 2^ADDR_W
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; arms a frame capture
- base_addr  input  ADDR_W  frame base address, latched on accepted start
- in_valid  input  1  result qualifier (pipeline en)
- in_x  input  8  horizontal edge result
- in_y  input  8  vertical edge result
- mem_ready  input  1  memory accepts the write this cycle
- mem_we  output  1  write request
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  16  write data
- busy  output  1  high in RUN or DRAIN
- done  output  1  one-cycle pulse at frame end
- overflow  output  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; FSM to IDLE; FIFO emptied; counters cleared.
  - Reset mid-frame abandons the frame; no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches base_addr, clears accept/write counters and overflow, then -> RUN. in_valid is ignored in IDLE.
  - RUN: in_valid=1 with FIFO not full pushes {in_x,in_y} and increments acc_cnt. When acc_cnt reaches T -> DRAIN. Results beyond T are never accepted.
  - DRAIN: no pushes; waits for FIFO empty and wr_cnt == T, then -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
  - start in RUN, DRAIN or DONE is ignored.
- FIFO boundary conditions:
  - in_valid with FIFO full in RUN: result dropped, acc_cnt not incremented, overflow set to 1 and held until the next accepted start.
  - Simultaneous push and pop while full: push is accepted.
- Write port:
  - mem_we, mem_addr and mem_wdata are registered.
  - A write completes on a rising edge with mem_we=1 and mem_ready=1.
  - While mem_we=1 and mem_ready=0, addr and data hold stable.
  - mem_addr = base_addr + wr_cnt, wrapping modulo 2^ADDR_W.
  - mem_wdata = {in_x, in_y} (x in bits 15:8).
  - After a completion the next entry is presented on the following cycle if the FIFO is non-empty; otherwise mem_we drops to 0.
- Latency: a result accepted at edge N gives earliest mem_we=1 after edge N+1. Sustained throughput is one write per cycle while mem_ready=1.
- busy = 1 in RUN and DRAIN.
- done asserts on the cycle after the last write completes.

Optional Feature:
- Macro: EDGE_WRITER_MAG_EN.
- When defined: mem_wdata = {8'h00, min(in_x+in_y, 255)}, a 9-bit sum saturated to 8 bits, computed at push time.
- When undefined: mem_wdata = {in_x, in_y}.
- All other behaviour is identical.

Test Plan:
- Run with IMG_W=4, IMG_H=2, base_addr=0x0100, mem_ready=1, 8 consecutive in_valid results x=i, y=0x10+i.
  - Required: writes at 0x0100..0x0107 with data 0x0010..0x0717.
  - done pulses once, one cycle after the 8th write; busy then falls to 0.
- Backpressure: mem_ready=0 for 5 cycles mid-frame with in_valid every other cycle.
  - Required: mem_addr and mem_wdata stable while stalled; no loss; overflow=0.
- Overflow: mem_ready=0 held, 6 results with FIFO_DEPTH=4.
  - Required: first 4 stored, overflow=1.
  - Frame still needs 8 total accepted results; done only after 8 writes; overflow stays 1 until the next start.
- Control misuse, each case separately:
  - in_valid pulses in IDLE: no writes.
  - start pulse during RUN: base_addr not relatched, counters not reset.
  - 10 results offered with T=8: only 8 written.
- Wrap and reset:
  - ADDR_W=16, base_addr=0xFFFE: addresses 0xFFFE, 0xFFFF, 0x0000, ...
  - rst=0 after 3 writes: outputs 0 immediately, no done; a new start begins again from base_addr.
- With EDGE_WRITER_MAG_EN: x=0xF0, y=0x20 -> wdata 0x00FF; x=0x12, y=0x34 -> wdata 0x0046.
